// File: rtl/uart_rx_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_pkt_ctrl
//
// Packet controller behind the UART receiver. Hunts for SYNC_BYTE in the
// received byte stream, collects a length-prefixed payload into an internal
// buffer, checks an XOR checksum (XOR of LEN and every payload byte) and
// only then drains the payload downstream on a valid/ready stream.
// Frame: SYNC, LEN (1..MAX_LEN), LEN payload bytes, CSUM.
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_rx_data    received byte, valid when i_rx_done=1
//   i_rx_done    1-cycle pulse per received byte
//   o_pkt_data   payload byte, valid when o_pkt_valid=1
//   o_pkt_valid  payload byte available
//   i_pkt_ready  downstream accepts the byte (handshake = valid & ready)
//   o_pkt_last   final payload byte, qualified by o_pkt_valid
//   o_pkt_ok     1-cycle pulse: checksum good, drain starts
//   o_pkt_err    1-cycle pulse: error, code on o_err_code
//   o_err_code   0=checksum 1=length 2=overrun 3=timeout; holds until next error
//   o_busy       controller is not idle
//
// Build option
//   RX_PKT_TIMEOUT_EN  when defined, an inter-byte timeout of TIMEOUT_CYC
//                      cycles aborts a partial frame with error code 3.
//                      When undefined a partial frame waits indefinitely.
// ---------------------------------------------------------------------------
module uart_rx_pkt_ctrl #(
    parameter int unsigned       D_BITS      = 8,
    parameter int unsigned       MAX_LEN     = 16,
    parameter logic [D_BITS-1:0] SYNC_BYTE   = 8'hA5,
    parameter int unsigned       TIMEOUT_CYC = 5000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [D_BITS-1:0] i_rx_data,
    input  logic              i_rx_done,
    output logic [D_BITS-1:0] o_pkt_data,
    output logic              o_pkt_valid,
    input  logic              i_pkt_ready,
    output logic              o_pkt_last,
    output logic              o_pkt_ok,
    output logic              o_pkt_err,
    output logic [1:0]        o_err_code,
    output logic              o_busy
);

    localparam int unsigned CW = $clog2(MAX_LEN + 1);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    if (MAX_LEN < 1 || MAX_LEN >= (1 << D_BITS) || TIMEOUT_CYC < 2) begin : g_param_check
        $error("uart_rx_pkt_ctrl: MAX_LEN must be 1..2**D_BITS-1 and TIMEOUT_CYC >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t            state;
    logic [CW-1:0]     len;
    logic [CW-1:0]     idx;
    logic [CW-1:0]     rd;
    logic [CW-1:0]     rd_next;
    logic [D_BITS-1:0] csum;
    logic [D_BITS-1:0] mem [MAX_LEN];

    logic [D_BITS-1:0] pkt_data;
    logic              pkt_valid;
    logic              pkt_last;
    logic              pkt_ok;
    logic              pkt_err;
    logic [1:0]        err_code;

    logic              len_bad;
    logic              expired;

    assign len_bad = (i_rx_data == '0) || (i_rx_data > D_BITS'(MAX_LEN));
    assign rd_next = rd + CW'(1);

`ifdef RX_PKT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] tcnt;
    logic          active;

    // Counts idle cycles since the last accepted byte while a frame is open.
    // A byte in the expiry cycle suppresses the timeout.
    assign active  = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
    assign expired = active && !i_rx_done && (tcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tcnt <= '0;
        end else if (!active || i_rx_done || expired) begin
            tcnt <= '0;
        end else if (tcnt != '1) begin
            tcnt <= tcnt + TW'(1);
        end
    end
`else
    assign expired = 1'b0;
`endif

    // Payload buffer: no reset, contents only meaningful after a full frame.
    always_ff @(posedge i_clk) begin
        if (state == S_PAYLOAD && i_rx_done) begin
            mem[idx[AW-1:0]] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            len       <= '0;
            idx       <= '0;
            rd        <= '0;
            csum      <= '0;
            pkt_data  <= '0;
            pkt_valid <= 1'b0;
            pkt_last  <= 1'b0;
            pkt_ok    <= 1'b0;
            pkt_err   <= 1'b0;
            err_code  <= '0;
        end else begin
            pkt_ok  <= 1'b0;
            pkt_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (i_rx_done && i_rx_data == SYNC_BYTE) begin
                        state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (i_rx_done) begin
                        if (len_bad) begin
                            pkt_err  <= 1'b1;
                            err_code <= 2'd1;
                            state    <= S_IDLE;
                        end else begin
                            len   <= CW'(i_rx_data);
                            csum  <= i_rx_data;
                            idx   <= '0;
                            state <= S_PAYLOAD;
                        end
                    end else if (expired) begin
                        pkt_err  <= 1'b1;
                        err_code <= 2'd3;
                        state    <= S_IDLE;
                    end
                end
                S_PAYLOAD: begin
                    if (i_rx_done) begin
                        csum <= csum ^ i_rx_data;
                        idx  <= idx + CW'(1);
                        if (idx == len - CW'(1)) begin
                            state <= S_CSUM;
                        end
                    end else if (expired) begin
                        pkt_err  <= 1'b1;
                        err_code <= 2'd3;
                        state    <= S_IDLE;
                    end
                end
                S_CSUM: begin
                    if (i_rx_done) begin
                        if (i_rx_data == csum) begin
                            // First byte is presented together with the ok pulse.
                            pkt_ok    <= 1'b1;
                            pkt_valid <= 1'b1;
                            pkt_data  <= mem[AW'(0)];
                            pkt_last  <= (len == CW'(1));
                            rd        <= '0;
                            state     <= S_DRAIN;
                        end else begin
                            pkt_err  <= 1'b1;
                            err_code <= 2'd0;
                            state    <= S_IDLE;
                        end
                    end else if (expired) begin
                        pkt_err  <= 1'b1;
                        err_code <= 2'd3;
                        state    <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    // Bytes arriving during the drain are dropped and flagged;
                    // the drain itself proceeds independently.
                    if (i_rx_done) begin
                        pkt_err  <= 1'b1;
                        err_code <= 2'd2;
                    end
                    if (i_pkt_ready) begin
                        if (pkt_last) begin
                            pkt_valid <= 1'b0;
                            pkt_last  <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            rd       <= rd_next;
                            pkt_data <= mem[rd_next[AW-1:0]];
                            pkt_last <= (rd_next == len - CW'(1));
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_pkt_data  = pkt_data;
    assign o_pkt_valid = pkt_valid;
    assign o_pkt_last  = pkt_last;
    assign o_pkt_ok    = pkt_ok;
    assign o_pkt_err   = pkt_err;
    assign o_err_code  = err_code;
    assign o_busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_pkt_ctrl
//
// Directed and randomized frames against a frame-parsing reference model.
// A negedge monitor collects handshaken payload bytes, ok pulses and error
// codes; the main sequence compares them with the model's expectations.
// ---------------------------------------------------------------------------
module tb_uart_rx_pkt_ctrl;

    localparam int unsigned D_BITS      = 8;
    localparam int unsigned MAX_LEN     = 16;
    localparam int unsigned TIMEOUT_CYC = 5000;

    typedef logic [7:0] bq8_t[$];

    logic       i_clk       = 1'b0;
    logic       i_rst_n     = 1'b0;
    logic [7:0] i_rx_data   = '0;
    logic       i_rx_done   = 1'b0;
    logic       i_pkt_ready = 1'b0;
    logic [7:0] o_pkt_data;
    logic       o_pkt_valid;
    logic       o_pkt_last;
    logic       o_pkt_ok;
    logic       o_pkt_err;
    logic [1:0] o_err_code;
    logic       o_busy;

    uart_rx_pkt_ctrl #(
        .D_BITS      (D_BITS),
        .MAX_LEN     (MAX_LEN),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .o_pkt_data  (o_pkt_data),
        .o_pkt_valid (o_pkt_valid),
        .i_pkt_ready (i_pkt_ready),
        .o_pkt_last  (o_pkt_last),
        .o_pkt_ok    (o_pkt_ok),
        .o_pkt_err   (o_pkt_err),
        .o_err_code  (o_err_code),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ready_mode  = 0;   // 0: ready low, 1: ready high, 2: random

    logic [8:0] got_bytes[$];
    int         got_cyc[$];
    int         got_errs[$];
    int         got_oks = 0;
    logic [8:0] exp_bytes[$];
    int         exp_errs[$];
    int         exp_oks = 0;

    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic       pl = 1'b0;
    logic [7:0] pd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge i_clk) cyc++;

    always @(posedge i_clk) begin
        #2;
        case (ready_mode)
            0:       i_pkt_ready = 1'b0;
            1:       i_pkt_ready = 1'b1;
            default: i_pkt_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("hold_valid", 32'(o_pkt_valid), 1);
                check("hold_data", 32'({o_pkt_last, o_pkt_data}), 32'({pl, pd}));
            end
            if (o_pkt_valid && i_pkt_ready) begin
                got_bytes.push_back({o_pkt_last, o_pkt_data});
                got_cyc.push_back(cyc);
            end
            if (o_pkt_ok) begin
                got_oks++;
                check("ok_with_valid", 32'(o_pkt_valid), 1);
                check("ok_first_valid", 32'(pv), 0);
                check("ok_err_excl", 32'(o_pkt_err), 0);
            end
            if (o_pkt_err) got_errs.push_back(int'(o_err_code));
            pv = o_pkt_valid;
            pr = i_pkt_ready;
            pl = o_pkt_last;
            pd = o_pkt_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick(1);
        i_rx_done = 1'b0;
        if (gap > 0) tick(gap);
    endtask

    task automatic send_frame(input bq8_t s, input int maxgap);
        foreach (s[k]) send_byte(s[k], int'($urandom_range(0, maxgap)));
    endtask

    // Reference: parse the byte stream by the frame rules, starting idle.
    task automatic model(input bq8_t s);
        int i, n, len;
        logic [7:0] x;
        i = 0;
        n = s.size();
        while (i < n) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            i++;
            if (i >= n) break;
            len = int'(s[i]);
            i++;
            if (len == 0 || len > int'(MAX_LEN)) begin
                exp_errs.push_back(1);
                continue;
            end
            if (i + len >= n) break;
            x = 8'(len);
            for (int k = 0; k < len; k++) x = x ^ s[i + k];
            if (s[i + len] == x) begin
                exp_oks++;
                for (int k = 0; k < len; k++) exp_bytes.push_back({k == len - 1, s[i + k]});
            end else begin
                exp_errs.push_back(0);
            end
            i += len + 1;
        end
    endtask

    task automatic flush();
        got_bytes.delete();
        got_cyc.delete();
        got_errs.delete();
        got_oks = 0;
        exp_bytes.delete();
        exp_errs.delete();
        exp_oks = 0;
    endtask

    task automatic compare_expect(input string tag);
        check({tag, "_oks"}, 32'(got_oks), 32'(exp_oks));
        check({tag, "_nbytes"}, 32'(got_bytes.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            check({tag, "_byte"}, 32'(got_bytes[i]), 32'(exp_bytes[i]));
        check({tag, "_nerrs"}, 32'(got_errs.size()), 32'(exp_errs.size()));
        for (int i = 0; i < exp_errs.size() && i < got_errs.size(); i++)
            check({tag, "_errcode"}, 32'(got_errs[i]), 32'(exp_errs[i]));
        flush();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (o_busy && n < 400) begin
            tick(1);
            n++;
        end
        check({tag, "_idle"}, 32'(o_busy), 0);
        tick(2);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!o_pkt_valid && n < 20) begin
            tick(1);
            n++;
        end
        check({tag, "_valid"}, 32'(o_pkt_valid), 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"},  32'(o_pkt_data), 0);
        check({tag, "_valid"}, 32'(o_pkt_valid), 0);
        check({tag, "_last"},  32'(o_pkt_last), 0);
        check({tag, "_ok"},    32'(o_pkt_ok), 0);
        check({tag, "_err"},   32'(o_pkt_err), 0);
        check({tag, "_code"},  32'(o_err_code), 0);
        check({tag, "_busy"},  32'(o_busy), 0);
    endtask

    task automatic async_reset(input string tag);
        @(posedge i_clk);
        #3;
        i_rst_n   = 1'b0;
        i_rx_done = 1'b0;
        #1;
        check_zero(tag);
        tick(2);
        i_rst_n = 1'b1;
        tick(1);
        flush();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq8_t       s;
        int         n, found_at, kind, len;
        logic [7:0] x, b;

        // Reset state
        tick(3);
        check_zero("reset");
        i_rst_n = 1'b1;
        tick(1);
        check_zero("post_reset");

        // 1: good frame, ready high, zero-bubble drain
        ready_mode = 1;
        s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        model(s);
        send_frame(s, 0);
        wait_idle("t1");
        if (got_cyc.size() == 3) begin
            check("t1_bubble_a", 32'(got_cyc[1] - got_cyc[0]), 1);
            check("t1_bubble_b", 32'(got_cyc[2] - got_cyc[1]), 1);
        end
        compare_expect("t1");

        // 2: bad checksum
        s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
        model(s);
        send_frame(s, 0);
        wait_idle("t2");
        check("t2_code", 32'(o_err_code), 0);
        compare_expect("t2");

        // 3: LEN 0 and LEN 17, then a 1-byte frame
        s = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'h7E, 8'h7F};
        model(s);
        send_frame(s, 1);
        wait_idle("t3");
        check("t3_code", 32'(o_err_code), 1);
        compare_expect("t3");

        // 4: backpressure holds first byte
        ready_mode = 0;
        s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        model(s);
        send_frame(s, 0);
        wait_valid("t4");
        tick(10);
        check("t4_held_valid", 32'(o_pkt_valid), 1);
        check("t4_held_data", 32'(o_pkt_data), 32'h11);
        check("t4_held_last", 32'(o_pkt_last), 0);
        ready_mode = 1;
        wait_idle("t4");
        compare_expect("t4");

        // 5: overrun during a stalled drain
        ready_mode = 0;
        model(s);
        send_frame(s, 0);
        wait_valid("t5");
        send_byte(8'h55, 2);
        check("t5_code", 32'(o_err_code), 2);
        exp_errs.push_back(2);
        ready_mode = 1;
        wait_idle("t5");
        compare_expect("t5");

        // 5b: overrun byte in the same cycle as the final handshake
        ready_mode = 0;
        s = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        model(s);
        send_frame(s, 0);
        wait_valid("t5b");
        ready_mode = 1;
        send_byte(8'h55, 0);
        exp_errs.push_back(2);
        wait_idle("t5b");
        check("t5b_code", 32'(o_err_code), 2);
        compare_expect("t5b");

        // Randomized frames, random ready, random gaps and leading noise
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            s.delete();
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                s.push_back(b);
            end
            kind = (f == 0) ? 0 : int'($urandom_range(0, 2));
            s.push_back(8'hA5);
            if (kind == 2) begin
                if ($urandom_range(0, 1) == 0) len = 0;
                else len = int'($urandom_range(MAX_LEN + 1, 255));
                s.push_back(8'(len));
            end else begin
                len = (f == 0) ? int'(MAX_LEN) : int'($urandom_range(1, MAX_LEN));
                s.push_back(8'(len));
                x = 8'(len);
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom_range(0, 255));
                    s.push_back(b);
                    x = x ^ b;
                end
                if (kind == 1) s.push_back(x ^ 8'($urandom_range(1, 255)));
                else s.push_back(x);
            end
            model(s);
            send_frame(s, 2);
            wait_idle("rand");
            compare_expect("rand");
        end

        // 6: partial frame then silence
        ready_mode = 1;
        s = '{8'hA5, 8'h02, 8'h11};
        send_frame(s, 0);
`ifdef RX_PKT_TIMEOUT_EN
        n = 0;
        found_at = -1;
        while (found_at < 0 && n < int'(TIMEOUT_CYC) + 10) begin
            tick(1);
            n++;
            if (o_pkt_err) begin
                found_at = n;
                check("t6_code", 32'(o_err_code), 3);
            end
        end
        check("t6_expiry_cycle", 32'(found_at), 32'(TIMEOUT_CYC));
        wait_idle("t6");
        exp_errs.push_back(3);
        compare_expect("t6");
        send_frame(s, 0);
`else
        tick(TIMEOUT_CYC + 1000);
        compare_expect("t6");
`endif
        check("t6_busy", 32'(o_busy), 1);

        // 7: reset mid-payload
        async_reset("t7_rst");
        check_zero("t7_after");

        // 8: reset during a stalled drain drops valid and ok asynchronously
        ready_mode = 0;
        s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_frame(s, 0);
        wait_valid("t8");
        async_reset("t8_rst");

        // Recovery after reset
        ready_mode = 2;
        model(s);
        send_frame(s, 1);
        wait_idle("t9");
        compare_expect("t9");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
